// File: rtl/pixel_plot_buffer.sv
// pixel_plot_buffer: pixel FIFO draining into a frame buffer, with a full-screen fill engine.
module pixel_plot_buffer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [8:0]  plotX,
  input  logic [7:0]  plotY,
  input  logic [2:0]  plotColour,
  input  logic        plotValid,
  output logic        plotReady,
  input  logic        clearRequest,
  input  logic [2:0]  clearColour,
  output logic [16:0] memAddress,
  output logic [2:0]  memData,
  output logic        memWren,
  output logic        busy,
  output logic        clearDone,
  output logic [6:0]  fifoCount
  ,output logic [7:0] dropCount
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  localparam logic [16:0] SW = 17'(SCREEN_W);
  localparam logic [16:0] SH = 17'(SCREEN_H);
  localparam logic [16:0] LAST = 17'(SCREEN_W * SCREEN_H - 1);

  logic [0:0]    state;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [6:0]    count;
  logic [19:0]   fifoMem [DEPTH];
  logic          popValid;
  logic [19:0]   popEntry;
  logic [16:0]   clearAddr;
  logic [2:0]    fillColour;
  logic          push, pop, inRange;
  logic [8:0]    px;
  logic [7:0]    py;
  logic [2:0]    pc;
  logic [16:0]   pixelAddr;

  assign plotReady = reset || (count != 7'(DEPTH));
  assign fifoCount = count;
  assign busy      = state == CLEAR;
  assign push      = plotValid && plotReady && !reset;
  assign pop       = state == IDLE && count != 7'd0;
  assign {px, py, pc} = popEntry;
  assign inRange   = 17'(px) < SW && 17'(py) < SH;
  assign pixelAddr = 17'(py) * SW + 17'(px);

  always_ff @(posedge clock)
    if (push) fifoMem[wrPtr] <= {plotX, plotY, plotColour};

  // A pop staged on the edge that enters CLEAR is written out before the fill advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      popValid   <= 1'b0;
      popEntry   <= '0;
      clearAddr  <= '0;
      fillColour <= '0;
      memAddress <= '0;
      memData    <= '0;
      memWren    <= 1'b0;
      clearDone  <= 1'b0;
      dropCount  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      count    <= count + 7'(push) - 7'(pop);
      popValid <= pop;
      if (pop) popEntry <= fifoMem[rdPtr];
      memWren   <= 1'b0;
      clearDone <= 1'b0;
      if (popValid) begin
        if (inRange) begin
          memWren    <= 1'b1;
          memAddress <= pixelAddr;
          memData    <= pc;
        end else if (dropCount != 8'hff) dropCount <= dropCount + 8'd1;
      end else if (state == CLEAR) begin
        memWren    <= 1'b1;
        memAddress <= clearAddr;
        memData    <= fillColour;
        clearAddr  <= clearAddr + 17'd1;
        if (clearAddr == LAST) begin
          state     <= IDLE;
          clearDone <= 1'b1;
        end
      end
      if (state == IDLE && clearRequest) begin
        state      <= CLEAR;
        fillColour <= clearColour;
        clearAddr  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_plot_buffer.sv
// tb_pixel_plot_buffer: directed stimulus against a queue-based behavioural model plus literal expectations.
module tb_pixel_plot_buffer;
  localparam int W = 320;
  localparam int H = 240;
  localparam int D = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  plotX;
  logic [7:0]  plotY;
  logic [2:0]  plotColour;
  logic        plotValid;
  logic        plotReady;
  logic        clearRequest;
  logic [2:0]  clearColour;
  logic [16:0] memAddress;
  logic [2:0]  memData;
  logic        memWren;
  logic        busy;
  logic        clearDone;
  logic [6:0]  fifoCount;
  logic [7:0]  dropCount;

  pixel_plot_buffer dut (
    .clock(clock), .reset(reset), .plotX(plotX), .plotY(plotY), .plotColour(plotColour),
    .plotValid(plotValid), .plotReady(plotReady), .clearRequest(clearRequest),
    .clearColour(clearColour), .memAddress(memAddress), .memData(memData), .memWren(memWren),
    .busy(busy), .clearDone(clearDone), .fifoCount(fifoCount), .dropCount(dropCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {int x; int y; int c;} pix_t;
  pix_t q[$];
  pix_t staged, popped;
  bit stV = 0, inClr = 0, popNow, accNow, wasClr;
  int fillNext = 0, fillCol = 0;
  bit eWren = 0, eDone = 0;
  int eAddr = 0, eData = 0, eDrop = 0;

  // Model: what the frame-buffer port must show after each edge, from queue semantics.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      stV = 0; inClr = 0; eWren = 0; eDone = 0; eAddr = 0; eData = 0; eDrop = 0;
    end else begin
      accNow = plotValid && q.size() != D;
      popNow = !inClr && q.size() > 0;
      if (popNow) popped = q.pop_front();
      wasClr = inClr;
      eWren = 0; eDone = 0;
      if (stV) begin
        if (staged.x < W && staged.y < H) begin
          eWren = 1; eAddr = staged.y * W + staged.x; eData = staged.c;
        end else if (eDrop < 255) eDrop++;
      end else if (inClr) begin
        eWren = 1; eAddr = fillNext; eData = fillCol;
        fillNext++;
        if (fillNext == W * H) begin inClr = 0; eDone = 1; end
      end
      if (!wasClr && clearRequest) begin inClr = 1; fillNext = 0; fillCol = int'(clearColour); end
      stV = popNow;
      if (popNow) staged = popped;
      if (accNow) q.push_back('{int'(plotX), int'(plotY), int'(plotColour)});
    end
  end

  logic [38:0] actVec, expVec;
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      actVec = {memWren, memAddress, memData, busy, clearDone, fifoCount, dropCount, plotReady};
      expVec = {eWren, 17'(eAddr), 3'(eData), inClr, eDone, 7'(q.size()), 8'(eDrop),
                reset || q.size() != D};
      checks++;
      if (actVec !== expVec) begin
        errors++;
        $display("FAIL model t=%0t got wren=%b addr=%0d data=%0d busy=%b done=%b cnt=%0d drop=%0d rdy=%b expected wren=%b addr=%0d data=%0d busy=%b done=%b cnt=%0d drop=%0d rdy=%b",
          $time, memWren, memAddress, memData, busy, clearDone, fifoCount, dropCount, plotReady,
          eWren, eAddr, eData, inClr, eDone, q.size(), eDrop, reset || q.size() != D);
      end
    end
  end

  task automatic push1(input int x, input int y, input int c);
    plotValid = 1; plotX = 9'(x); plotY = 8'(y); plotColour = 3'(c);
    @(negedge clock);
    plotValid = 0;
  endtask

  int busyCycles, doneCount, fillWrites, orderErr, acc, nextFill, seen;
  bit found;
  int got[$];

  initial begin
    reset = 1; plotValid = 1; plotX = 9'd1; plotY = 8'd1; plotColour = 3'd1;
    clearRequest = 0; clearColour = 0;
    repeat (3) @(negedge clock);
    check("rst_ready", int'(plotReady), 1);
    check("rst_count", int'(fifoCount), 0);
    check("rst_wren", int'(memWren), 0);
    check("rst_addr", int'(memAddress), 0);
    check("rst_data", int'(memData), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(clearDone), 0);
    check("rst_drop", int'(dropCount), 0);
    plotValid = 0; reset = 0;
    @(negedge clock);

    push1(5, 2, 3);
    check("lat_k_wren", int'(memWren), 0);
    @(negedge clock);
    check("lat_k1_wren", int'(memWren), 0);
    @(negedge clock);
    check("lat_k2_wren", int'(memWren), 1);
    check("lat_k2_addr", int'(memAddress), 645);
    check("lat_k2_data", int'(memData), 3);
    @(negedge clock);
    check("lat_k3_wren", int'(memWren), 0);

    push1(320, 0, 1);
    push1(0, 240, 2);
    seen = 0;
    repeat (4) begin @(negedge clock); if (memWren) seen++; end
    check("drop_wren", seen, 0);
    check("drop_two", int'(dropCount), 2);
    for (int i = 0; i < 300; i++) begin
      plotValid = 1; plotX = 9'(320 + i % 192); plotY = 8'(i % 240); plotColour = 3'(i % 8);
      @(negedge clock);
    end
    plotValid = 0;
    repeat (4) @(negedge clock);
    check("drop_sat", int'(dropCount), 255);

    clearRequest = 1; clearColour = 3'd5;
    @(negedge clock);
    busyCycles = 0; doneCount = 0; fillWrites = 0; orderErr = 0; acc = 0; nextFill = 0; found = 0;
    for (int cyc = 0; cyc < 80000 && !found; cyc++) begin
      if (busy) busyCycles++;
      if (clearDone) doneCount++;
      if (memWren && (busy || clearDone)) begin
        fillWrites++;
        if (int'(memAddress) != nextFill || memData != 3'd5) orderErr++;
        nextFill++;
      end
      if (cyc == 15) begin
        check("full_count", int'(fifoCount), 8);
        check("full_ready", int'(plotReady), 0);
      end
      if (clearDone) found = 1;
      else begin
        plotValid = cyc < 10;
        if (cyc < 10) begin
          if (plotReady) acc++;
          plotX = 9'(10 + cyc); plotY = 8'(cyc); plotColour = 3'(cyc % 8);
        end
        clearRequest = cyc == 20;
        clearColour = (cyc == 20) ? 3'd2 : 3'd5;
        @(negedge clock);
      end
    end
    plotValid = 0; clearRequest = 0;
    check("fill_found", int'(found), 1);
    check("fill_accepted", acc, 8);
    check("fill_busy_cycles", busyCycles, 76800);
    check("fill_done_pulses", doneCount, 1);
    check("fill_writes", fillWrites, 76800);
    check("fill_order", orderErr, 0);

    for (int j = 0; j < 40; j++) begin
      plotValid = j >= 5 && j < 25;
      plotX = 9'(100 + j - 5); plotY = 8'd50; plotColour = 3'((j - 5) % 8);
      @(negedge clock);
      if (memWren) got.push_back(int'(memAddress));
      if (j >= 5 && j < 25) check("steady_count", int'(fifoCount), 3);
    end
    plotValid = 0;
    check("drain_len", got.size(), 28);
    for (int k = 0; k < 28 && k < got.size(); k++)
      check("drain_order", got[k], (k < 8) ? k * W + 10 + k : 50 * W + 100 + (k - 8));

    clearRequest = 1; clearColour = 3'd6;
    @(negedge clock);
    clearRequest = 0; found = 0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      if (memWren && memAddress == 17'd1000) found = 1;
      else begin
        plotValid = cyc >= 2 && cyc < 5;
        plotX = 9'(cyc); plotY = 8'(cyc); plotColour = 3'd1;
        @(negedge clock);
      end
    end
    plotValid = 0;
    check("abort_found", int'(found), 1);
    check("abort_fifo_pre", int'(fifoCount), 3);
    reset = 1;
    @(negedge clock);
    check("abort_wren", int'(memWren), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(clearDone), 0);
    check("abort_fifo", int'(fifoCount), 0);
    reset = 0;
    seen = 0;
    repeat (20) begin @(negedge clock); if (memWren || clearDone) seen++; end
    check("abort_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
